chunked_rca_adder: RTL
======================

// Module: chunked_rca_adder
// PURPOSE
//   Multi-cycle, parametrised ripple-carry adder: adds two WIDTH-bit operands plus
//   carry-in, CHUNK bits per clock, carry registered between chunks.
//   Successor to the fixed 4-bit RCA: generalised width, start/done handshake,
//   signed-overflow flag. Used where a full-width ripple chain misses timing.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; must be a multiple of CHUNK
//   CHUNK   4  bits added per cycle (ripple of full adders); 1 <= CHUNK <= WIDTH
//   NCHUNK = WIDTH/CHUNK (localparam); chunk counter is clog2(NCHUNK) bits, min 1
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request; accepted only when ready=1
//   a      in   WIDTH  operand A, sampled on accepting edge
//   b      in   WIDTH  operand B, sampled on accepting edge
//   c_in   in   1      carry-in, sampled on accepting edge
//   ready  out  1      high only in IDLE
//   busy   out  1      high in ADD
//   done   out  1      one-cycle pulse: sum/c_out/ovf valid
//   sum    out  WIDTH  result
//   c_out  out  1      carry out of bit WIDTH-1
//   ovf    out  1      two's-complement overflow
// BEHAVIOUR
//   Reset (rst high at an edge): state=IDLE; ready=1; busy=0; done=0; sum=0;
//     c_out=0; ovf=0; operand regs, carry and chunk index cleared. Takes priority
//     over every other event, including mid-ADD and in DONE: op aborted, no done.
//   FSM: IDLE -> ADD -> DONE -> IDLE.
//   IDLE: on edge with start=1, latch a, b, c_in; carry<=c_in; idx<=0; -> ADD.
//     start=0: stay. sum/c_out/ovf keep last completed result.
//   ADD: each edge processes chunk idx (bits idx*CHUNK +: CHUNK):
//     {carry, sum[chunk]} <= a[chunk] + b[chunk] + carry; idx<=idx+1.
//     After the edge processing idx=NCHUNK-1: c_out<=carry-out, ovf set, -> DONE.
//     sum bits are partial while busy=1; not valid.
//   DONE: done=1 for exactly one cycle; next edge -> IDLE. No sum/c_out/ovf change.
//   start while ready=0 (ADD or DONE) ignored: no latch, no queue, no effect.
//   Latency: start accepted at edge E0; done high in the cycle after edge E_NCHUNK,
//     i.e. NCHUNK cycles after acceptance; ready returns one cycle later.
//     Throughput: one add per NCHUNK+2 cycles (next start accepted earliest in
//     the cycle after done).
//   CHUNK=WIDTH: single ADD cycle; done one cycle after acceptance.
//   Arithmetic: unsigned modulo 2^WIDTH; {c_out,sum} == a + b + c_in exactly.
//     ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]) on latched operands;
//     c_in included in the sum.
//   Outputs ready/busy/done decoded from registered state: no combinational path
//     from any input to any output.
// TESTING
//   1 rst=1 two edges, then 0 -> ready=1, busy=0, done=0, sum=0, c_out=0, ovf=0.
//   2 W16/C4: a=FFFF b=0001 c_in=0 start 1 cycle -> done 4 cycles after accept;
//     sum=0000 c_out=1 ovf=0; ready=1 next cycle.
//   3 a=7FFF b=0000 c_in=1 -> sum=8000 c_out=0 ovf=1.
//     a=8000 b=8000 c_in=0 -> sum=0000 c_out=1 ovf=1.
//   4 start held high throughout; new a/b applied during ADD ->
//     exactly one done per FSM round; result from first latched operands only;
//     next op accepted in the cycle after done.
//   5 rst pulse after 2 ADD edges -> no done ever for that op;
//     outputs cleared; ready=1 after reset released.
//   6 Self-check vs behavioural a+b+c_in, flag mismatches at done:
//     exhaustive for W8/C2 and W8/C8; 10k random vectors for W16/C4 and W32/C1.

Source files
------------

// File: rtl/chunked_rca_adder.sv
// Multi-cycle ripple-carry adder. Each clock adds one CHUNK-bit slice of the
// operands, and the carry is registered between slices.
module chunked_rca_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [IDX_W-1:0] idx;
   int               base;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic             last_chunk;

   // Slice selection and ripple adder for the chunk currently being processed.
   always_comb begin
      base       = int'(idx) * CHUNK;
      a_chunk    = op_a[base +: CHUNK];
      b_chunk    = op_b[base +: CHUNK];
      chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
      last_chunk = (idx == LAST_IDX);
   end

   // NOTE: give every always_comb output a default first so that no path can leave
   // it unassigned; an unassigned path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ADD;
         S_ADD:   if (last_chunk) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments only. Each register then
   // samples pre-edge values, and the order of the statements does not matter.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= c_in;
                  idx   <= '0;
               end
            end
            S_ADD: begin
               sum[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
               carry              <= chunk_sum[CHUNK];
               idx                <= idx + 1'b1;
               if (last_chunk) begin
                  c_out <= chunk_sum[CHUNK];
                  // Bit CHUNK-1 of the last chunk is the sign bit of the sum.
                  ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                           (chunk_sum[CHUNK-1] != op_a[WIDTH-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign ready = (state == S_IDLE);
   assign busy  = (state == S_ADD);
   assign done  = (state == S_DONE);

endmodule
